// File: rtl/pipe_stage_seq.sv
// Front-end pipeline stage: registers fetched bytes with decode-ROM control, tags operand bytes,
// and handles stall, flush, bubbles and a post-reset NOP fill with fetch suppression.
module pipe_stage_seq #(
   parameter int unsigned       DATA_W     = 8,
   parameter int unsigned       CTRL_W     = 16,
   parameter int unsigned       IMM_MAX    = 2,
   parameter int unsigned       RESET_NOPS = 3,
   parameter logic [DATA_W-1:0] NOP_OPCODE = '0,
   localparam int unsigned      IW         = $clog2(IMM_MAX + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] pipe_in,
   input  logic              pipe_in_valid,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [IW-1:0]     imm_count_in,
   input  logic              bus_request,
   input  logic              flush,
   output logic [DATA_W-1:0] pipe_out,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic              valid_out,
   output logic              is_operand,
   output logic [IW-1:0]     operand_idx,
   output logic              busy,
   output logic              fetch_suppress
);

   localparam int unsigned RW = (RESET_NOPS > 0) ? $clog2(RESET_NOPS + 1) : 1;

   typedef enum logic [1:0] {StFill, StOpcode, StOperand} state_e;

   state_e            r_state;
   logic [IW-1:0]     r_remaining;
   logic [IW-1:0]     r_count;
   logic [RW-1:0]     r_fill_cnt;
   logic [DATA_W-1:0] r_pipe_out;
   logic [CTRL_W-1:0] r_ctrl_out;
   logic              r_valid_out;
   logic              r_is_operand;
   logic [IW-1:0]     r_operand_idx;
   logic              r_busy;
   logic              r_fetch_suppress;

   logic [IW-1:0]     w_imm_clamped;
   logic              w_flush;
   logic              w_advance;

   assign w_imm_clamped = (imm_count_in > IW'(IMM_MAX)) ? IW'(IMM_MAX) : imm_count_in;
   // Flush cannot cut the reset fill short.
   assign w_flush       = flush && (r_state != StFill);
   assign w_advance     = w_flush || !bus_request;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= (RESET_NOPS > 0) ? StFill : StOpcode;
         r_fill_cnt       <= RW'(RESET_NOPS);
         r_fetch_suppress <= (RESET_NOPS > 0);
         r_remaining      <= '0;
         r_count          <= '0;
         r_pipe_out       <= NOP_OPCODE;
         r_ctrl_out       <= '0;
         r_valid_out      <= 1'b0;
         r_is_operand     <= 1'b0;
         r_operand_idx    <= '0;
         r_busy           <= 1'b0;
      end else if (w_advance) begin
         // Bubble by default; real bytes override below.
         r_pipe_out    <= NOP_OPCODE;
         r_ctrl_out    <= '0;
         r_valid_out   <= 1'b0;
         r_is_operand  <= 1'b0;
         r_operand_idx <= '0;
         if (w_flush) begin
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_state     <= StOpcode;
         end else begin
            unique case (r_state)
               StFill: begin
                  r_fill_cnt <= r_fill_cnt - RW'(1);
                  if (r_fill_cnt == RW'(1)) begin
                     r_state          <= StOpcode;
                     r_fetch_suppress <= 1'b0;
                  end
               end
               StOpcode: begin
                  if (pipe_in_valid) begin
                     r_pipe_out  <= pipe_in;
                     r_ctrl_out  <= ctrl_in;
                     r_valid_out <= 1'b1;
                     r_remaining <= w_imm_clamped;
                     r_count     <= w_imm_clamped;
                     if (w_imm_clamped != '0) begin
                        r_state <= StOperand;
                        r_busy  <= 1'b1;
                     end
                  end
               end
               StOperand: begin
                  if (pipe_in_valid) begin
                     r_pipe_out    <= pipe_in;
                     r_valid_out   <= 1'b1;
                     r_is_operand  <= 1'b1;
                     r_operand_idx <= r_count - r_remaining + IW'(1);
                     r_remaining   <= r_remaining - IW'(1);
                     if (r_remaining == IW'(1)) begin
                        r_state <= StOpcode;
                        r_busy  <= 1'b0;
                     end
                  end
               end
               default: begin
                  r_state     <= StOpcode;
                  r_remaining <= '0;
                  r_busy      <= 1'b0;
               end
            endcase
         end
      end
   end

   assign pipe_out       = r_pipe_out;
   assign ctrl_out       = r_ctrl_out;
   assign valid_out      = r_valid_out;
   assign is_operand     = r_is_operand;
   assign operand_idx    = r_operand_idx;
   assign busy           = r_busy;
   assign fetch_suppress = r_fetch_suppress;

endmodule

// File: tb/tb_pipe_stage_seq.sv
// Bench for pipe_stage_seq: directed vector table, hand-written corner sequences, and random
// stimulus against a queue-based reference model.
module tb_pipe_stage_seq;

   localparam int unsigned DATA_W     = 8;
   localparam int unsigned CTRL_W     = 16;
   localparam int unsigned IMM_MAX    = 2;
   localparam int unsigned RESET_NOPS = 3;
   localparam int unsigned IW         = 2;
   localparam logic [7:0]  NOP        = 8'h00;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [DATA_W-1:0] pipe_in = '0;
   logic              pipe_in_valid = 1'b0;
   logic [CTRL_W-1:0] ctrl_in = '0;
   logic [IW-1:0]     imm_count_in = '0;
   logic              bus_request = 1'b0;
   logic              flush = 1'b0;
   logic [DATA_W-1:0] pipe_out;
   logic [CTRL_W-1:0] ctrl_out;
   logic              valid_out;
   logic              is_operand;
   logic [IW-1:0]     operand_idx;
   logic              busy;
   logic              fetch_suppress;

   always #5 clk = ~clk;

   pipe_stage_seq #(
      .DATA_W     (DATA_W),
      .CTRL_W     (CTRL_W),
      .IMM_MAX    (IMM_MAX),
      .RESET_NOPS (RESET_NOPS),
      .NOP_OPCODE (NOP)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pipe_in        (pipe_in),
      .pipe_in_valid  (pipe_in_valid),
      .ctrl_in        (ctrl_in),
      .imm_count_in   (imm_count_in),
      .bus_request    (bus_request),
      .flush          (flush),
      .pipe_out       (pipe_out),
      .ctrl_out       (ctrl_out),
      .valid_out      (valid_out),
      .is_operand     (is_operand),
      .operand_idx    (operand_idx),
      .busy           (busy),
      .fetch_suppress (fetch_suppress)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: bubbles still owed after reset, and a queue of operand indices still owed.
   int          m_fill;
   int          m_owed[$];
   logic [7:0]  e_out;
   logic [15:0] e_ctrl;
   logic        e_valid, e_isop, e_busy, e_fs;
   logic [1:0]  e_idx;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic m_bubble();
      e_out = NOP; e_ctrl = '0; e_valid = 1'b0; e_isop = 1'b0; e_idx = '0;
   endtask

   task automatic m_reset();
      m_fill = RESET_NOPS;
      m_owed.delete();
      m_bubble();
      e_busy = 1'b0;
      e_fs   = (RESET_NOPS > 0);
   endtask

   task automatic m_step(input logic v, input logic [7:0] b, input logic [15:0] c,
                         input logic [1:0] imm, input logic bus, input logic fl);
      int k;
      if (fl && m_fill == 0) begin
         m_bubble();
         m_owed.delete();
      end else if (bus) begin
         // everything holds
      end else if (m_fill > 0) begin
         m_bubble();
         m_fill--;
      end else if (!v) begin
         m_bubble();
      end else if (m_owed.size() == 0) begin
         e_out = b; e_ctrl = c; e_valid = 1'b1; e_isop = 1'b0; e_idx = '0;
         k = (int'(imm) > IMM_MAX) ? IMM_MAX : int'(imm);
         for (int i = 1; i <= k; i++) m_owed.push_back(i);
      end else begin
         e_out = b; e_ctrl = '0; e_valid = 1'b1; e_isop = 1'b1;
         e_idx = 2'(m_owed.pop_front());
      end
      e_busy = (m_owed.size() != 0);
      e_fs   = (m_fill > 0);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pipe_out"},    32'(pipe_out),       32'(e_out));
      chk({tag, ".ctrl_out"},    32'(ctrl_out),       32'(e_ctrl));
      chk({tag, ".valid_out"},   32'(valid_out),      32'(e_valid));
      chk({tag, ".is_operand"},  32'(is_operand),     32'(e_isop));
      chk({tag, ".operand_idx"}, 32'(operand_idx),    32'(e_idx));
      chk({tag, ".busy"},        32'(busy),           32'(e_busy));
      chk({tag, ".fetch_supp"},  32'(fetch_suppress), 32'(e_fs));
   endtask

   task automatic drive(input logic v, input logic [7:0] b, input logic [15:0] c,
                        input logic [1:0] imm, input logic bus, input logic fl);
      pipe_in_valid = v; pipe_in = b; ctrl_in = c; imm_count_in = imm;
      bus_request = bus; flush = fl;
   endtask

   task automatic cycle(input string tag, input logic v, input logic [7:0] b,
                        input logic [15:0] c, input logic [1:0] imm, input logic bus,
                        input logic fl);
      drive(v, b, c, imm, bus, fl);
      m_step(v, b, c, imm, bus, fl);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      m_reset();
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        v;
      logic [7:0]  b;
      logic [15:0] c;
      logic [1:0]  imm;
      logic        bus;
      logic        fl;
      logic [7:0]  x_out;
      logic [15:0] x_ctrl;
      logic        x_valid;
      logic        x_isop;
      logic [1:0]  x_idx;
      logic        x_busy;
   } vec_t;

   vec_t tbl[15];

   initial begin
      tbl[0]  = '{1'b1, 8'h80, 16'hA5C3, 2'd2, 1'b0, 1'b0, 8'h80, 16'hA5C3, 1'b1, 1'b0, 2'd0, 1'b1};
      tbl[1]  = '{1'b1, 8'h12, 16'hFFFF, 2'd3, 1'b0, 1'b0, 8'h12, 16'h0000, 1'b1, 1'b1, 2'd1, 1'b1};
      tbl[2]  = '{1'b1, 8'h34, 16'hFFFF, 2'd1, 1'b0, 1'b0, 8'h34, 16'h0000, 1'b1, 1'b1, 2'd2, 1'b0};
      tbl[3]  = '{1'b1, 8'h05, 16'h1234, 2'd0, 1'b0, 1'b0, 8'h05, 16'h1234, 1'b1, 1'b0, 2'd0, 1'b0};
      tbl[4]  = '{1'b1, 8'h80, 16'hA5C3, 2'd2, 1'b0, 1'b0, 8'h80, 16'hA5C3, 1'b1, 1'b0, 2'd0, 1'b1};
      tbl[5]  = '{1'b1, 8'h12, 16'h7777, 2'd0, 1'b0, 1'b0, 8'h12, 16'h0000, 1'b1, 1'b1, 2'd1, 1'b1};
      tbl[6]  = '{1'b0, 8'hEE, 16'h7777, 2'd0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1};
      tbl[7]  = '{1'b1, 8'h34, 16'h7777, 2'd0, 1'b0, 1'b0, 8'h34, 16'h0000, 1'b1, 1'b1, 2'd2, 1'b0};
      tbl[8]  = '{1'b1, 8'h90, 16'h0F0F, 2'd3, 1'b0, 1'b0, 8'h90, 16'h0F0F, 1'b1, 1'b0, 2'd0, 1'b1};
      tbl[9]  = '{1'b1, 8'hAA, 16'h1111, 2'd0, 1'b0, 1'b0, 8'hAA, 16'h0000, 1'b1, 1'b1, 2'd1, 1'b1};
      tbl[10] = '{1'b1, 8'hBB, 16'h2222, 2'd0, 1'b0, 1'b0, 8'hBB, 16'h0000, 1'b1, 1'b1, 2'd2, 1'b0};
      tbl[11] = '{1'b1, 8'hCC, 16'h0001, 2'd0, 1'b0, 1'b0, 8'hCC, 16'h0001, 1'b1, 1'b0, 2'd0, 1'b0};
      tbl[12] = '{1'b1, 8'h80, 16'hA5C3, 2'd2, 1'b0, 1'b0, 8'h80, 16'hA5C3, 1'b1, 1'b0, 2'd0, 1'b1};
      tbl[13] = '{1'b1, 8'h12, 16'h5555, 2'd0, 1'b1, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0};
      tbl[14] = '{1'b1, 8'h12, 16'h5555, 2'd0, 1'b0, 1'b0, 8'h12, 16'h5555, 1'b1, 1'b0, 2'd0, 1'b0};

      #2;
      do_reset();

      // Reset fill: three bubbles, suppression drops on the third edge, 0x41 accepted on the fourth.
      for (int i = 1; i <= 4; i++) cycle($sformatf("fill%0d", i), 1'b1, 8'h41, 16'h0BAD, 2'd0,
                                         1'b0, 1'b0);
      chk("first_accept", 32'(pipe_out), 32'h41);

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].v, tbl[i].b, tbl[i].c, tbl[i].imm, tbl[i].bus, tbl[i].fl);
         m_step(tbl[i].v, tbl[i].b, tbl[i].c, tbl[i].imm, tbl[i].bus, tbl[i].fl);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d.pipe_out", i),    32'(pipe_out),    32'(tbl[i].x_out));
         chk($sformatf("vec%0d.ctrl_out", i),    32'(ctrl_out),    32'(tbl[i].x_ctrl));
         chk($sformatf("vec%0d.valid_out", i),   32'(valid_out),   32'(tbl[i].x_valid));
         chk($sformatf("vec%0d.is_operand", i),  32'(is_operand),  32'(tbl[i].x_isop));
         chk($sformatf("vec%0d.operand_idx", i), 32'(operand_idx), 32'(tbl[i].x_idx));
         chk($sformatf("vec%0d.busy", i),        32'(busy),        32'(tbl[i].x_busy));
      end

      // Stall for 4 cycles mid-operand: outputs frozen, then idx 2 resumes.
      cycle("st_op", 1'b1, 8'h80, 16'hA5C3, 2'd2, 1'b0, 1'b0);
      cycle("st_b1", 1'b1, 8'h12, 16'h0000, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle($sformatf("stall%0d", i), 1'b1, 8'h34, 16'h0000, 2'd0, 1'b1, 1'b0);
         chk($sformatf("stall%0d.frozen_idx", i), 32'(operand_idx), 32'd1);
      end
      cycle("st_b2", 1'b1, 8'h34, 16'h0000, 2'd0, 1'b0, 1'b0);
      chk("stall.resume_idx", 32'(operand_idx), 32'd2);

      // Reset mid-operand: partial instruction dropped, fill restarts, 0x34 becomes an opcode.
      cycle("rm_op", 1'b1, 8'h80, 16'hA5C3, 2'd2, 1'b0, 1'b0);
      cycle("rm_b1", 1'b1, 8'h12, 16'h0000, 2'd0, 1'b0, 1'b0);
      do_reset();
      chk("rm.fetch_supp", 32'(fetch_suppress), 32'd1);
      // Flush during fill is ignored.
      cycle("rm_f1", 1'b1, 8'h34, 16'h4321, 2'd0, 1'b0, 1'b1);
      for (int i = 2; i <= 4; i++) cycle($sformatf("rm_f%0d", i), 1'b1, 8'h34, 16'h4321, 2'd0,
                                         1'b0, 1'b0);
      chk("rm.opcode_ctrl", 32'(ctrl_out), 32'h4321);

      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         cycle("rnd", 1'($urandom_range(0, 3) != 0), 8'($urandom), 16'($urandom),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0),
               1'($urandom_range(0, 9) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_seq.md
# pipe_stage_seq

Parametrised front-end pipeline stage for the JAM-1 CPU, generalising the first decode stage. It registers each fetched byte together with the control word produced by the external decode ROM. It tracks multi-byte instructions so that operand (immediate) bytes pass through tagged as data with control forced to zero. It also handles bus-request stalls, synchronous flush, bubble insertion and a post-reset NOP fill with fetch suppression. It sits between the instruction fetch register and stage 2.

## Interface
Parameters:
- DATA_W, 8: width of the fetched byte / opcode.
- CTRL_W, 16: width of the decoded control word (LHS, RHS, ALUOP, XLD, XA, …).
- IMM_MAX, 2: maximum operand bytes following an opcode; IMM_MAX ≥ 1.
- RESET_NOPS, 3: NOP bubbles emitted after reset before fetch is accepted; may be 0.
- NOP_OPCODE, 8'h00: value driven on pipe_out for any bubble.

Derived widths:
- IW = $clog2(IMM_MAX+1).
- RW = max(1, $clog2(RESET_NOPS+1)).

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- pipe_in, in, DATA_W: fetched byte.
- pipe_in_valid, in, 1: pipe_in holds a real byte this cycle.
- ctrl_in, in, CTRL_W: decode-ROM control word for pipe_in (used only for opcodes).
- imm_count_in, in, IW: decode-ROM operand-byte count for pipe_in (used only for opcodes).
- bus_request, in, 1: stall; the stage holds all state.
- flush, in, 1: discard the in-flight instruction.
- pipe_out, out, DATA_W: registered byte.
- ctrl_out, out, CTRL_W: registered control word; zero for operands and bubbles.
- valid_out, out, 1: pipe_out is a real opcode or operand.
- is_operand, out, 1: pipe_out is an operand byte.
- operand_idx, out, IW: 1-based index of the operand byte; 0 for opcodes and bubbles.
- busy, out, 1: operand bytes are still expected.
- fetch_suppress, out, 1: fetch must not advance PC (high during reset fill).

## Operation
States and counters:
- States: FILL, OPCODE, OPERAND.
- remaining (IW bits): operand bytes still owed.
- fill_cnt (RW bits): NOP bubbles still to emit.

Reset (rst_n low, asynchronous):
- pipe_out = NOP_OPCODE; ctrl_out = 0; valid_out = 0; is_operand = 0; operand_idx = 0; busy = 0; remaining = 0.
- If RESET_NOPS > 0: state = FILL, fill_cnt = RESET_NOPS, fetch_suppress = 1.
- Otherwise: state = OPCODE, fetch_suppress = 0.

Priority, per clock, highest first: reset, flush, bus_request, normal advance.

- **flush:** emit a bubble, set remaining = 0 and state = OPCODE. In FILL, flush is ignored; the fill completes normally.
- **bus_request:** every register holds, including fill_cnt. The producer holds pipe_in.
- **FILL:** emit a bubble each cycle and decrement fill_cnt; pipe_in is ignored. Leave for OPCODE on the cycle fill_cnt reaches 0. fetch_suppress falls on that same edge.
- **OPCODE, pipe_in_valid = 1:**
  - Drive pipe_out = pipe_in, ctrl_out = ctrl_in, valid_out = 1, is_operand = 0, operand_idx = 0.
  - Set remaining = min(imm_count_in, IMM_MAX), clamped.
  - If remaining > 0, go to OPERAND and set busy = 1.
- **OPERAND, pipe_in_valid = 1:**
  - Drive pipe_out = pipe_in, ctrl_out = 0, valid_out = 1, is_operand = 1.
  - operand_idx = (clamped count − remaining + 1).
  - Decrement remaining. When it reaches 0, go to OPCODE and clear busy.
- **pipe_in_valid = 0 in OPCODE or OPERAND:** emit a bubble; state and remaining are unchanged.
- **Bubble:** pipe_out = NOP_OPCODE, ctrl_out = 0, valid_out = 0, is_operand = 0, operand_idx = 0.

## Timing
- Latency: input sampled at edge N appears on outputs after edge N; no combinational input-to-output paths.
- Throughput: one byte per cycle when unstalled.
- An instruction with k operand bytes occupies k+1 accepted cycles. Bubbles may interleave without breaking the sequence.
- Reset release: the first accepted byte is sampled at edge RESET_NOPS+1 after rst_n rises.
- Reset asserted mid-sequence clears the partial instruction immediately; no operand byte is emitted afterwards.
- flush and bus_request together: flush wins and a bubble is produced.

## Test plan
- Reset, RESET_NOPS=3, pipe_in_valid=1 throughout → 3 bubbles with fetch_suppress=1, then byte 0x41 accepted at edge 4; fetch_suppress=0 from edge 3.
- Opcode 0x80 with imm_count_in=2, ctrl_in=16'hA5C3, then bytes 0x12, 0x34, then 0x05 (imm 0) → outputs:
  - 0x80 / A5C3 / idx 0
  - 0x12 / 0000 / idx 1 / is_operand
  - 0x34 / 0000 / idx 2 / is_operand
  - 0x05 opcode with its own ctrl_in.
- Same sequence with pipe_in_valid low between 0x12 and 0x34 → bubble inserted, then 0x34 still tagged idx 2, busy high across the bubble.
- bus_request held 4 cycles mid-operand → all outputs frozen for 4 cycles; the sequence resumes with the correct idx.
- flush on the cycle after opcode 0x80 (imm 2), with bus_request also high → bubble emitted; next byte 0x12 is decoded as an opcode with ctrl_out = ctrl_in.
- imm_count_in=3 with IMM_MAX=2 → only 2 operand bytes tagged, third treated as an opcode. Separately, rst_n pulsed low mid-operand → outputs reset immediately and FILL restarts.
